// File: rtl/sigma_delta_modulator.sv
// Second-order single-bit saturating sigma-delta modulator with overload recovery
// and optional LFSR dither at the quantizer input.
module sigma_delta_modulator #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned SAT_LIMIT = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [IN_WIDTH-1:0] input_data,
  input  logic                dither_en,
  output logic                dout,
  output logic                ce_out,
  output logic                overload,
  output logic                recover
);

  localparam int unsigned SumW = ACC_WIDTH + 2;
  localparam logic signed [SumW-1:0] AccMax = {3'b000, {(ACC_WIDTH - 1){1'b1}}};
  localparam logic signed [SumW-1:0] AccMin = {3'b111, {(ACC_WIDTH - 1){1'b0}}};
  localparam logic signed [SumW-1:0] Fs =
      {{(SumW - IN_WIDTH){1'b0}}, 1'b1, {(IN_WIDTH - 1){1'b0}}};
  localparam logic signed [SumW-1:0] NegFs = -Fs;
  localparam logic signed [SumW-1:0] Zero = '0;
  localparam logic [7:0] SatLast = 8'(SAT_LIMIT - 1);

  logic signed [ACC_WIDTH-1:0] int1_q, int1_d, int2_q, int2_d;
  logic signed [ACC_WIDTH-1:0] int1_clamp, int2_clamp;
  logic        [15:0]          lfsr_q, lfsr_d;
  logic        [7:0]           sat_cnt_q, sat_cnt_d;
  logic                        dout_q, ce_q, recover_q;

  logic signed [SumW-1:0] int1_ext, int2_ext, int1_new_ext, x_ext, dith, quant;
  logic signed [SumW-1:0] y_val, sum1, sum2;
  logic                   y_pos, sat1, sat2, sat, sat_last;

  always_comb begin
    int1_ext = {{2{int1_q[ACC_WIDTH-1]}}, int1_q};
    int2_ext = {{2{int2_q[ACC_WIDTH-1]}}, int2_q};
    x_ext    = {{(SumW - IN_WIDTH){input_data[IN_WIDTH-1]}}, input_data};
    dith     = dither_en ? {{(SumW - 8){lfsr_q[7]}}, lfsr_q[7:0]} : Zero;
    quant    = int2_ext + dith;
    y_pos    = (quant >= Zero);
    y_val    = y_pos ? Fs : NegFs;

    sum1 = int1_ext + x_ext - y_val;
    sat1 = 1'b0;
    if (sum1 > AccMax) begin
      int1_clamp = AccMax[ACC_WIDTH-1:0];
      sat1       = 1'b1;
    end else if (sum1 < AccMin) begin
      int1_clamp = AccMin[ACC_WIDTH-1:0];
      sat1       = 1'b1;
    end else begin
      int1_clamp = sum1[ACC_WIDTH-1:0];
    end

    // Second integrator consumes the already-clamped first integrator value.
    int1_new_ext = {{2{int1_clamp[ACC_WIDTH-1]}}, int1_clamp};
    sum2 = int2_ext + int1_new_ext - y_val;
    sat2 = 1'b0;
    if (sum2 > AccMax) begin
      int2_clamp = AccMax[ACC_WIDTH-1:0];
      sat2       = 1'b1;
    end else if (sum2 < AccMin) begin
      int2_clamp = AccMin[ACC_WIDTH-1:0];
      sat2       = 1'b1;
    end else begin
      int2_clamp = sum2[ACC_WIDTH-1:0];
    end

    sat      = sat1 | sat2;
    sat_last = sat && (sat_cnt_q == SatLast);

    int1_d    = sat_last ? '0 : int1_clamp;
    int2_d    = sat_last ? '0 : int2_clamp;
    sat_cnt_d = (sat && !sat_last) ? sat_cnt_q + 8'd1 : 8'd0;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int1_q    <= '0;
      int2_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      sat_cnt_q <= '0;
      dout_q    <= 1'b0;
      ce_q      <= 1'b0;
      recover_q <= 1'b0;
    end else begin
      ce_q      <= clk_enable;
      recover_q <= clk_enable & sat_last;
      if (clk_enable) begin
        int1_q    <= int1_d;
        int2_q    <= int2_d;
        lfsr_q    <= lfsr_d;
        sat_cnt_q <= sat_cnt_d;
        dout_q    <= y_pos;
      end
    end
  end

  assign dout     = dout_q;
  assign ce_out   = ce_q;
  assign overload = |sat_cnt_q;
  assign recover  = recover_q;

endmodule
